// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encodings, opcode/funct constants, ALU operation codes, ALU status bit
// positions and the per-state control word.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11,
        ST_HALT      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Codes must match the ALU's own decoder bit-for-bit.
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_SLT = 5'b01011;
    localparam logic [4:0] ALU_NOR = 5'b11000;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRL = 5'b00101;

    localparam int unsigned STATUS_C = 0;
    localparam int unsigned STATUS_Z = 1;
    localparam int unsigned STATUS_N = 2;
    localparam int unsigned STATUS_V = 3;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       ior_d;
        logic       ir_write;
        logic       pc_en;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore control word for a state; the BEQ pcEn term is added in the top
    // because it depends on the live zero flag.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'd1;
                c.pc_en     = 1'b1;
            end
            ST_DECODE:    c.alu_src_b = 2'd3;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            ST_R_EXEC:    c.alu_src_a = 1'b1;
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.pc_source = 2'd1;
            end
            ST_JUMP: begin
                c.pc_source = 2'd2;
                c.pc_en     = 1'b1;
            end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            ST_I_WB:      c.reg_write = 1'b1;
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decode.sv
// alu_decode: combinational map from (state, opcode, funct) to the ALU
// operation code, plus a flag telling whether funct is a supported R-type op.
//   state_i        state whose ALU operation is wanted
//   opcode_i       instr[31:26]
//   funct_i        instr[5:0]
//   alu_control_o  ALU operation code
//   funct_valid_o  1 when funct_i is a supported R-type function
module alu_decode
    import mips_multicycle_control_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [4:0] alu_control_o,
    output logic       funct_valid_o
);

    // ALU operation selected by state, then by funct or opcode
    always_comb begin
        alu_control_o = ALU_AND;
        case (state_i)
            ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_control_o = ALU_ADD;
            ST_BRANCH:                        alu_control_o = ALU_SUB;
            ST_R_EXEC: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_NOR:  alu_control_o = ALU_NOR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    FN_SLL:  alu_control_o = ALU_SLL;
                    FN_SRL:  alu_control_o = ALU_SRL;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            ST_I_EXEC: begin
                case (opcode_i)
                    OP_ADDI: alu_control_o = ALU_ADD;
                    OP_ANDI: alu_control_o = ALU_AND;
                    OP_ORI:  alu_control_o = ALU_OR;
                    OP_SLTI: alu_control_o = ALU_SLT;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_AND;
        endcase
    end

    // Kept separate from the block above: it must not depend on state, since
    // the FSM feeds it back into its own next-state logic.
    always_comb begin
        funct_valid_o = 1'b0;
        case (funct_i)
            FN_ADD, FN_SUB, FN_AND, FN_OR,
            FN_NOR, FN_SLT, FN_SLL, FN_SRL: funct_valid_o = 1'b1;
            default:                        funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (Moore). Controls are registered together with
// the state; only pcEn has a live term (zero flag during BRANCH). Strobes are
// masked while reset is high.
//   clock, reset                  clock and synchronous active-high reset
//   instr                         instruction register contents
//   statusIn                      ALU status flags {V,N,Z,C}
//   aluControl/aluStatusIn/aluSrcA/aluSrcB   ALU controls
//   regWrite/regDst/memToReg      register-file controls
//   memRead/memWrite/iorD/irWrite memory and IR controls
//   pcEn/pcSource                 PC update controls
//   illegalOp                     sticky unsupported-instruction flag
//   state                         current FSM state
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [3:0]            statusIn,
    output logic [4:0]            aluControl,
    output logic [3:0]            aluStatusIn,
    output logic                  aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic                  regWrite,
    output logic                  regDst,
    output logic                  memToReg,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  iorD,
    output logic                  irWrite,
    output logic                  pcEn,
    output logic [1:0]            pcSource,
    output logic                  illegalOp,
    output logic [3:0]            state
);

    state_e     state_q;
    state_e     state_d;
    state_e     state_nxt_s;
    ctrl_t      ctrl_q;
    logic [4:0] alu_ctrl_q;
    logic [4:0] alu_ctrl_s;
    logic       funct_valid_s;
    logic       illegal_q;
    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic       unused_s;

    assign opcode_s = instr[31:26];
    assign funct_s  = instr[5:0];
    assign unused_s = ^{instr[25:6], statusIn[3:2], statusIn[0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode_s)
                    OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
                    OP_RTYPE:                          state_d = ST_R_EXEC;
                    OP_BEQ:                            state_d = ST_BRANCH;
                    OP_J:                              state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_I_EXEC;
                    default:                           state_d = ST_HALT;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode_s == OP_LW) begin
                    state_d = ST_MEM_READ;
                end else begin
                    state_d = ST_MEM_WRITE;
                end
            end
            ST_MEM_READ:  state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = ST_FETCH;
            ST_R_EXEC: begin
                if (funct_valid_s) begin
                    state_d = ST_R_WB;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_R_WB:   state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_I_EXEC: state_d = ST_I_WB;
            ST_I_WB:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    // The ALU code is decoded for the state being entered so that it can be
    // registered alongside it.
    assign state_nxt_s = reset ? ST_FETCH : state_d;

    alu_decode u_alu_decode (
        .state_i       (state_nxt_s),
        .opcode_i      (opcode_s),
        .funct_i       (funct_s),
        .alu_control_o (alu_ctrl_s),
        .funct_valid_o (funct_valid_s)
    );

    // State, registered control word and sticky illegal flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            ctrl_q     <= state_ctrl(ST_FETCH);
            alu_ctrl_q <= alu_ctrl_s;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= state_ctrl(state_d);
            alu_ctrl_q <= alu_ctrl_s;
            illegal_q  <= illegal_q | (state_d == ST_HALT);
        end
    end

    assign state       = state_q;
    assign illegalOp   = illegal_q;
    assign aluStatusIn = 4'b0000;
    assign aluControl  = alu_ctrl_q;
    assign aluSrcA     = ctrl_q.alu_src_a;
    assign aluSrcB     = ctrl_q.alu_src_b;
    assign regDst      = ctrl_q.reg_dst;
    assign memToReg    = ctrl_q.mem_to_reg;
    assign iorD        = ctrl_q.ior_d;
    assign pcSource    = ctrl_q.pc_source;
    assign regWrite    = ctrl_q.reg_write & ~reset;
    assign memRead     = ctrl_q.mem_read  & ~reset;
    assign memWrite    = ctrl_q.mem_write & ~reset;
    assign irWrite     = ctrl_q.ir_write  & ~reset;
    assign pcEn        = (ctrl_q.pc_en | ((state_q == ST_BRANCH) & statusIn[STATUS_Z])) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: directed instructions followed by random ones, each
// compared cycle by cycle against a per-instruction-class reference model.
module tb_mips_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [3:0]  statusIn = 4'h0;
    logic [4:0]  aluControl;
    logic [3:0]  aluStatusIn;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic        regWrite, regDst, memToReg, memRead, memWrite, iorD, irWrite, pcEn;
    logic [1:0]  pcSource;
    logic        illegalOp;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;
    bit il_m  = 1'b0;

    mips_multicycle_control #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .instr(instr), .statusIn(statusIn),
        .aluControl(aluControl), .aluStatusIn(aluStatusIn), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
        .pcEn(pcEn), .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        return fn inside {6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 5'b00010;
            6'h22:   return 5'b01010;
            6'h24:   return 5'b00000;
            6'h25:   return 5'b00001;
            6'h27:   return 5'b11000;
            6'h2A:   return 5'b01011;
            6'h00:   return 5'b00100;
            default: return 5'b00101;
        endcase
    endfunction

    function automatic logic [4:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 5'b00010;
            6'h0C:   return 5'b00000;
            6'h0D:   return 5'b00001;
            default: return 5'b01011;
        endcase
    endfunction

    // Expected outputs of one cycle spent in state st with instruction ins.
    task automatic check_cycle(input int st, input logic [31:0] ins);
        logic rw, rd, m2r, mr, mw, iord, irw, pce, asa;
        logic [1:0] asb, pcs;
        logic [4:0] alu;
        bit alu_chk;
        {rw, rd, m2r, mr, mw, iord, irw, pce, asa} = 9'b0;
        asb = 2'd0; pcs = 2'd0; alu = 5'b00010; alu_chk = 1'b0;
        if (st == 12) il_m = 1'b1;
        case (st)
            0:  begin mr = 1'b1; irw = 1'b1; asb = 2'd1; pce = 1'b1; alu_chk = 1'b1; end
            1:  begin asb = 2'd3; alu_chk = 1'b1; end
            2:  begin asa = 1'b1; asb = 2'd2; alu_chk = 1'b1; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; alu = r_alu(ins[5:0]); alu_chk = fn_legal(ins[5:0]); end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin asa = 1'b1; pcs = 2'd1; pce = statusIn[1]; alu = 5'b01010; alu_chk = 1'b1; end
            9:  begin pcs = 2'd2; pce = 1'b1; end
            10: begin asa = 1'b1; asb = 2'd2; alu = i_alu(ins[31:26]); alu_chk = 1'b1; end
            11: begin rw = 1'b1; end
            default: ;
        endcase
        chk($sformatf("state@%0d", st), state, st);
        chk($sformatf("illegalOp@%0d", st), illegalOp, il_m);
        chk("aluStatusIn", aluStatusIn, 4'b0000);
        chk($sformatf("regWrite@%0d", st), regWrite, rw);
        chk($sformatf("regDst@%0d", st), regDst, rd);
        chk($sformatf("memToReg@%0d", st), memToReg, m2r);
        chk($sformatf("memRead@%0d", st), memRead, mr);
        chk($sformatf("memWrite@%0d", st), memWrite, mw);
        chk($sformatf("iorD@%0d", st), iorD, iord);
        chk($sformatf("irWrite@%0d", st), irWrite, irw);
        chk($sformatf("pcEn@%0d", st), pcEn, pce);
        chk($sformatf("aluSrcA@%0d", st), aluSrcA, asa);
        chk($sformatf("aluSrcB@%0d", st), aluSrcB, asb);
        chk($sformatf("pcSource@%0d", st), pcSource, pcs);
        if (alu_chk) chk($sformatf("aluControl@%0d", st), aluControl, alu);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 in the FETCH cycle.
    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        chk("rst_regWrite", regWrite, 1'b0);
        chk("rst_memRead", memRead, 1'b0);
        chk("rst_memWrite", memWrite, 1'b0);
        chk("rst_irWrite", irWrite, 1'b0);
        chk("rst_pcEn", pcEn, 1'b0);
        @(posedge clock); #1;
        il_m = 1'b0;
        chk("rst_state", state, 4'd0);
        chk("rst_illegalOp", illegalOp, 1'b0);
        chk("rst_strobes", {regWrite, memRead, memWrite, irWrite, pcEn}, 5'b0);
        chk("rst_aluStatusIn", aluStatusIn, 4'b0000);
        reset = 1'b0;
    endtask

    // Runs one instruction from its FETCH cycle; fixed_st < 0 means random status.
    task automatic run_instr(input logic [31:0] ins, input int fixed_st);
        int q[$];
        logic [5:0] op;
        op = ins[31:26];
        instr = ins;
        q = '{0, 1};
        if (op == 6'h23)      q = '{0, 1, 2, 3, 4};
        else if (op == 6'h2B) q = '{0, 1, 2, 5};
        else if (op == 6'h00) q = fn_legal(ins[5:0]) ? '{0, 1, 6, 7} : '{0, 1, 6, 12};
        else if (op == 6'h04) q = '{0, 1, 8};
        else if (op == 6'h02) q = '{0, 1, 9};
        else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D}) q = '{0, 1, 10, 11};
        else                  q = '{0, 1, 12};
        foreach (q[i]) begin
            statusIn = (fixed_st < 0) ? 4'($urandom_range(0, 15)) : 4'(fixed_st);
            #1;
            check_cycle(q[i], ins);
            @(posedge clock); #1;
        end
        if (q[q.size()-1] == 12) begin
            for (int k = 0; k < 10; k++) begin
                statusIn = 4'($urandom_range(0, 15));
                #1;
                check_cycle(12, ins);
                @(posedge clock); #1;
            end
            reset_pulse();
        end
    endtask

    initial begin
        logic [5:0]  ops [9];
        logic [5:0]  fns [8];
        logic [31:0] r;
        logic [5:0]  op, fn;
        ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

        @(posedge clock); #1;
        reset_pulse();

        run_instr(32'h00221820, -1);   // add $3,$1,$2
        run_instr(32'h8C220004, -1);   // lw
        run_instr(32'hAC220004, -1);   // sw
        run_instr(32'h10220003, 2);    // beq, zero set
        run_instr(32'h10220003, 0);    // beq, zero clear
        run_instr(32'h08000010, -1);   // j
        run_instr(32'h3022000F, -1);   // andi
        run_instr(32'hFC000000, -1);   // illegal opcode
        run_instr(32'h00221801, -1);   // illegal funct

        // Reset asserted in MEM_READ of a lw: no write-back may follow.
        instr = 32'h8C220004;
        for (int s = 0; s < 4; s++) begin
            statusIn = 4'($urandom_range(0, 15));
            #1;
            check_cycle(s, instr);
            if (s < 3) begin
                @(posedge clock); #1;
            end
        end
        reset_pulse();
        run_instr(32'h00221822, -1);   // sub after the aborted lw

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                op = ops[$urandom_range(0, 8)];
            end else begin
                op = 6'h3F;
                for (int t = 0; t < 64; t++) begin
                    op = 6'($urandom_range(0, 63));
                    if (!op_legal(op)) break;
                end
                if (op_legal(op)) op = 6'h3F;
            end
            fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
            run_instr({op, r[25:6], fn}, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
